// File: rtl/fpu_arb_pkg.sv
// Shared FSM state type and constants for the FPU adder request arbiter.
package fpu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   localparam logic [2:0] EXC_TIMEOUT = 3'b111;
   localparam int         NREQ_DEF    = 4;
   localparam int         TIMEOUT_DEF = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module rr_arbiter import fpu_arb_pkg::*; #(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int IW = $clog2(NREQ);

   logic [IW:0] slot;

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      slot  = '0;
      for (int k = 0; k < NREQ; k++) begin
         // One extra bit lets ptr+k wrap correctly for non-power-of-two NREQ.
         slot = {1'b0, ptr} + (IW+1)'(k);
         if (slot >= (IW+1)'(NREQ)) slot = slot - (IW+1)'(NREQ);
         if (!any && req[slot[IW-1:0]]) begin
            any                  = 1'b1;
            idx                  = slot[IW-1:0];
            grant[slot[IW-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter giving NREQ requesters shared, one-at-a-time access
// to an FPU adder controller, with a watchdog on the controller response.
module fpu_add_arbiter import fpu_arb_pkg::*; #(
   parameter int NREQ    = NREQ_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NREQ-1:0]         Req_valid,
   output logic [NREQ-1:0]         Req_ready,
   input  logic [NREQ*32-1:0]      Req_data1,
   input  logic [NREQ*32-1:0]      Req_data2,
   input  logic [NREQ*3-1:0]       Req_mode,
   output logic [NREQ-1:0]         Rsp_valid,
   output logic [31:0]             Rsp_data,
   output logic [2:0]              Rsp_exc,
   output logic [$clog2(NREQ)-1:0] Rsp_id,
   output logic                    Busy,
   output logic [31:0]             Datain1,
   output logic [31:0]             Datain2,
   output logic [2:0]              Mode,
   output logic                    Data_valid,
   input  logic [31:0]             Dataout,
   input  logic                    Dataout_valid,
   input  logic [2:0]              Exc
);

   localparam int IW = $clog2(NREQ);
   localparam int WW = $clog2(TIMEOUT + 1);

   arb_state_t      state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   cur_idx;
   logic [NREQ-1:0] cur_onehot;
   logic [WW-1:0]   wdog;

   logic [NREQ-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            grant_ok;
   logic [31:0]     sel_d1;
   logic [31:0]     sel_d2;
   logic [2:0]      sel_mode;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (Req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // A controller still holding Dataout_valid (e.g. after a reset) blocks new grants.
   assign grant_ok  = (state == IDLE) && !Dataout_valid && !RST;
   assign Req_ready = grant_ok ? pick_grant : '0;

   always_comb begin
      sel_d1   = '0;
      sel_d2   = '0;
      sel_mode = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == IW'(i)) begin
            sel_d1   = Req_data1[32*i +: 32];
            sel_d2   = Req_data2[32*i +: 32];
            sel_mode = Req_mode[3*i +: 3];
         end
      end
   end

   // NOTE: all state and registered outputs use non-blocking assignments.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         ptr        <= '0;
         wdog       <= '0;
         cur_idx    <= '0;
         cur_onehot <= '0;
         Data_valid <= 1'b0;
         Busy       <= 1'b0;
         Rsp_valid  <= '0;
         Rsp_data   <= '0;
         Rsp_exc    <= '0;
         Rsp_id     <= '0;
         Datain1    <= '0;
         Datain2    <= '0;
         Mode       <= '0;
      end else begin
         Rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (grant_ok && pick_any) begin
                  Datain1    <= sel_d1;
                  Datain2    <= sel_d2;
                  Mode       <= sel_mode;
                  cur_idx    <= pick_idx;
                  cur_onehot <= pick_grant;
                  ptr        <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                  wdog       <= '0;
                  Data_valid <= 1'b1;
                  Busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (Dataout_valid) begin
                  Rsp_data   <= Dataout;
                  Rsp_exc    <= Exc;
                  Rsp_id     <= cur_idx;
                  Rsp_valid  <= cur_onehot;
                  Data_valid <= 1'b0;
                  state      <= DRAIN;
               end else if (wdog == WW'(TIMEOUT - 1)) begin
                  // TIMEOUT full cycles in ISSUE with no answer: fail the request.
                  Rsp_data   <= '0;
                  Rsp_exc    <= EXC_TIMEOUT;
                  Rsp_id     <= cur_idx;
                  Rsp_valid  <= cur_onehot;
                  Data_valid <= 1'b0;
                  state      <= DRAIN;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            DRAIN: begin
               if (!Dataout_valid) begin
                  Busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Self-checking bench for fpu_add_arbiter with a scripted adder-controller stub.
module tb_fpu_add_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;

   logic                CLK;
   logic                RST;
   logic [NREQ-1:0]     Req_valid;
   logic [NREQ-1:0]     Req_ready;
   logic [NREQ*32-1:0]  Req_data1;
   logic [NREQ*32-1:0]  Req_data2;
   logic [NREQ*3-1:0]   Req_mode;
   logic [NREQ-1:0]     Rsp_valid;
   logic [31:0]         Rsp_data;
   logic [2:0]          Rsp_exc;
   logic [1:0]          Rsp_id;
   logic                Busy;
   logic [31:0]         Datain1;
   logic [31:0]         Datain2;
   logic [2:0]          Mode;
   logic                Data_valid;
   logic [31:0]         Dataout;
   logic                Dataout_valid;
   logic [2:0]          Exc;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  exc;
      int          id;
   } exp_t;

   exp_t exp_q[$];
   int   grant_log[$];
   exp_t mon_e;
   logic [NREQ-1:0] mon_oh;

   int total;
   int bad;
   int rsp_seen;

   bit stub_on;
   int stub_hold;
   int stub_force;
   int hold_cnt;

   fpu_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .Req_valid     (Req_valid),
      .Req_ready     (Req_ready),
      .Req_data1     (Req_data1),
      .Req_data2     (Req_data2),
      .Req_mode      (Req_mode),
      .Rsp_valid     (Rsp_valid),
      .Rsp_data      (Rsp_data),
      .Rsp_exc       (Rsp_exc),
      .Rsp_id        (Rsp_id),
      .Busy          (Busy),
      .Datain1       (Datain1),
      .Datain2       (Datain2),
      .Mode          (Mode),
      .Data_valid    (Data_valid),
      .Dataout       (Dataout),
      .Dataout_valid (Dataout_valid),
      .Exc           (Exc)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   // Adder-controller stub: known float sums, otherwise integer sum; Exc echoes Mode.
   function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40300000 && b == 32'h40B00000) return 32'h41040000;
      if (a == 32'hC0300000 && b == 32'h40B00000) return 32'h40300000;
      if (a == 32'h42140000 && b == 32'hC2480000) return 32'hC1500000;
      return a + b;
   endfunction

   function automatic bit stub_known(input logic [31:0] a, input logic [31:0] b);
      return (a == 32'h40300000 && b == 32'h40B00000) ||
             (a == 32'hC0300000 && b == 32'h40B00000) ||
             (a == 32'h42140000 && b == 32'hC2480000);
   endfunction

   initial begin
      Dataout_valid = 1'b0;
      Dataout       = '0;
      Exc           = '0;
      hold_cnt      = 0;
      forever begin
         @(posedge CLK); #1;
         if (stub_force > 0) begin
            Dataout_valid = 1'b1;
            stub_force--;
            hold_cnt = stub_hold;
         end else if (Dataout_valid) begin
            if (hold_cnt < stub_hold) hold_cnt++;
            else Dataout_valid = 1'b0;
         end else if (stub_on && Data_valid) begin
            Dataout       = stub_sum(Datain1, Datain2);
            Exc           = stub_known(Datain1, Datain2) ? 3'b000 : Mode;
            Dataout_valid = 1'b1;
            hold_cnt      = 0;
         end
      end
   end

   // Response monitor: every Rsp_valid pulse must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge CLK);
         if (Rsp_valid !== '0) begin
            rsp_seen++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected Rsp_valid=%b Rsp_data=%h", Rsp_valid, Rsp_data);
            end else begin
               mon_e  = exp_q.pop_front();
               mon_oh = '0;
               mon_oh[mon_e.id] = 1'b1;
               if (Rsp_valid !== mon_oh || Rsp_data !== mon_e.data ||
                   Rsp_exc !== mon_e.exc || Rsp_id !== 2'(mon_e.id)) begin
                  bad++;
                  $display("FAIL rsp_match got valid=%b data=%h exc=%b id=%0d expected valid=%b data=%h exc=%b id=%0d",
                           Rsp_valid, Rsp_data, Rsp_exc, Rsp_id, mon_oh, mon_e.data, mon_e.exc, mon_e.id);
               end
            end
         end
      end
   end

   task automatic set_slot(input int i, input logic [31:0] d1, input logic [31:0] d2, input logic [2:0] m);
      Req_data1[32*i +: 32] = d1;
      Req_data2[32*i +: 32] = d2;
      Req_mode[3*i +: 3]    = m;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [2:0] x, input int id);
      exp_t e;
      e.data = d;
      e.exc  = x;
      e.id   = id;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RST       = 1'b1;
      Req_valid = '0;
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   // Runs until n more responses arrive, logging every grant and optionally dropping it.
   task automatic run_ops(input int n, input bit drop, input int max_cycles, input string tag);
      int target;
      logic [NREQ-1:0] mask;
      target = rsp_seen + n;
      for (int c = 0; c < max_cycles && rsp_seen < target; c++) begin
         mask = '0;
         @(negedge CLK);
         if (Req_ready !== '0) begin
            total++;
            if ($countones(Req_ready) != 1) begin
               bad++;
               $display("FAIL %s_onehot Req_ready=%b expected exactly one bit", tag, Req_ready);
            end
            for (int i = NREQ - 1; i >= 0; i--)
               if (Req_ready[i]) mask = NREQ'(1) << i;
            for (int i = 0; i < NREQ; i++)
               if (mask[i]) grant_log.push_back(i);
            if (!drop) mask = '0;
         end
         @(posedge CLK); #1;
         Req_valid = Req_valid & ~mask;
      end
      total++;
      if (rsp_seen < target) begin
         bad++;
         $display("FAIL %s_wait got %0d responses expected %0d", tag, n - (target - rsp_seen), n);
      end
   endtask

   task automatic check_order(input int exp_order[$], input string tag);
      total++;
      if (grant_log.size() != exp_order.size()) begin
         bad++;
         $display("FAIL %s_order_len got %0d grants expected %0d", tag, grant_log.size(), exp_order.size());
      end else begin
         for (int i = 0; i < exp_order.size(); i++) begin
            if (grant_log[i] != exp_order[i]) begin
               bad++;
               $display("FAIL %s_order grant[%0d]=%0d expected %0d", tag, i, grant_log[i], exp_order[i]);
               break;
            end
         end
      end
   endtask

   task automatic test_reset();
      RST       = 1'b1;
      Req_valid = '1;
      for (int i = 0; i < NREQ; i++) set_slot(i, 32'hDEAD0000 + i, 32'hBEEF0000 + i, 3'd5);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      total++;
      if (Req_ready !== '0 || Data_valid !== 1'b0 || Busy !== 1'b0 || Rsp_valid !== '0) begin
         bad++;
         $display("FAIL reset_ctrl ready=%b dv=%b busy=%b rsp_valid=%b expected all zero",
                  Req_ready, Data_valid, Busy, Rsp_valid);
      end
      total++;
      if (Rsp_data !== '0 || Rsp_exc !== '0 || Rsp_id !== '0 ||
          Datain1 !== '0 || Datain2 !== '0 || Mode !== '0) begin
         bad++;
         $display("FAIL reset_data rsp=%h exc=%b id=%0d din1=%h din2=%h mode=%b expected all zero",
                  Rsp_data, Rsp_exc, Rsp_id, Datain1, Datain2, Mode);
      end
      @(posedge CLK); #1;
      Req_valid = '0;
      RST       = 1'b0;
      @(negedge CLK);
      total++;
      if (Busy !== 1'b0 || Req_ready !== '0) begin
         bad++;
         $display("FAIL reset_release busy=%b ready=%b expected 0 and 0000", Busy, Req_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      stub_on   = 1'b1;
      stub_hold = 0;
      set_slot(0, 32'h40300000, 32'h40B00000, 3'd0);
      push_exp(32'h41040000, 3'b000, 0);
      Req_valid = 4'b0001;
      @(negedge CLK);
      total++;
      if (Req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL single_ready Req_ready=%b expected 0001", Req_ready);
      end
      @(posedge CLK); #1;
      Req_valid = '0;
      @(negedge CLK);
      total++;
      if (Data_valid !== 1'b1 || Busy !== 1'b1 || Datain1 !== 32'h40300000 ||
          Datain2 !== 32'h40B00000 || Mode !== 3'd0) begin
         bad++;
         $display("FAIL single_issue dv=%b busy=%b din1=%h din2=%h mode=%b expected 1 1 40300000 40b00000 000",
                  Data_valid, Busy, Datain1, Datain2, Mode);
      end
      @(negedge CLK);
      total++;
      if (Rsp_valid !== 4'b0001 || Data_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_latency Rsp_valid=%b dv=%b expected 0001 0", Rsp_valid, Data_valid);
      end
      @(negedge CLK);
      total++;
      if (Rsp_valid !== '0 || Busy !== 1'b0 || Rsp_data !== 32'h41040000 || Rsp_id !== 2'd0) begin
         bad++;
         $display("FAIL single_after Rsp_valid=%b busy=%b data=%h id=%0d expected 0000 0 41040000 0",
                  Rsp_valid, Busy, Rsp_data, Rsp_id);
      end
   endtask

   task automatic test_simultaneous();
      int order[$];
      do_reset();
      grant_log.delete();
      set_slot(0, 32'hC0300000, 32'h40B00000, 3'd0);
      set_slot(2, 32'h42140000, 32'hC2480000, 3'd0);
      push_exp(32'h40300000, 3'b000, 0);
      push_exp(32'hC1500000, 3'b000, 2);
      Req_valid = 4'b0101;
      run_ops(2, 1'b1, 50, "simul");
      order = '{0, 2};
      check_order(order, "simul");
   endtask

   task automatic test_round_robin();
      int order[$];
      logic [31:0] d1 [NREQ];
      logic [31:0] d2 [NREQ];
      do_reset();
      grant_log.delete();
      for (int i = 0; i < NREQ; i++) begin
         d1[i] = 32'h0100_0ABC + 32'h0100_0000 * i;
         d2[i] = 32'h0000_1000 << i;
         set_slot(i, d1[i], d2[i], 3'(i + 1));
      end
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NREQ; i++) push_exp(d1[i] + d2[i], 3'(i + 1), i);
      Req_valid = '1;
      run_ops(8, 1'b0, 200, "rr");
      Req_valid = '0;
      order = '{0, 1, 2, 3, 0, 1, 2, 3};
      check_order(order, "rr");
   endtask

   task automatic test_timeout();
      int n;
      bit found;
      stub_on = 1'b0;
      n       = 0;
      found   = 1'b0;
      set_slot(1, 32'h12345678, 32'h9ABCDEF0, 3'd2);
      push_exp(32'h0, 3'b111, 1);
      Req_valid = 4'b0010;
      @(negedge CLK);
      total++;
      if (Req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL timeout_ready Req_ready=%b expected 0010", Req_ready);
      end
      @(posedge CLK); #1;
      Req_valid = '0;
      for (int c = 0; c < 200; c++) begin
         @(negedge CLK);
         if (Rsp_valid !== '0) begin
            found = 1'b1;
            break;
         end
         if (Data_valid === 1'b1) n++;
      end
      total++;
      if (!found || n != TIMEOUT) begin
         bad++;
         $display("FAIL timeout_cycles issue_cycles=%0d response_seen=%0d expected %0d and 1", n, found, TIMEOUT);
      end
      @(negedge CLK);
      total++;
      if (Busy !== 1'b0 || Data_valid !== 1'b0) begin
         bad++;
         $display("FAIL timeout_idle busy=%b dv=%b expected 0 0", Busy, Data_valid);
      end
      stub_on = 1'b1;
   endtask

   task automatic test_reset_in_issue();
      int saved;
      stub_on = 1'b0;
      @(posedge CLK); #1;
      set_slot(0, 32'h11111111, 32'h22222222, 3'd3);
      Req_valid = 4'b0001;
      @(posedge CLK); #1;
      Req_valid = '0;
      repeat (3) @(negedge CLK);
      total++;
      if (Data_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_issue_pre dv=%b expected 1", Data_valid);
      end
      saved      = rsp_seen;
      RST        = 1'b1;
      stub_force = 3;
      set_slot(2, 32'h00000123, 32'h00000456, 3'd4);
      Req_valid  = 4'b0100;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      total++;
      if (Data_valid !== 1'b0 || Busy !== 1'b0 || Rsp_valid !== '0 || Datain1 !== '0) begin
         bad++;
         $display("FAIL rst_issue_after dv=%b busy=%b rsp_valid=%b din1=%h expected 0 0 0000 0",
                  Data_valid, Busy, Rsp_valid, Datain1);
      end
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge CLK);
         total++;
         if (Dataout_valid !== 1'b1 || Req_ready !== '0) begin
            bad++;
            $display("FAIL rst_block_%0d ready=%b dout_valid=%b expected 0000 1", c, Req_ready, Dataout_valid);
         end
      end
      @(negedge CLK);
      total++;
      if (Dataout_valid !== 1'b0 || Req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL rst_unblock ready=%b dout_valid=%b expected 0100 0", Req_ready, Dataout_valid);
      end
      total++;
      if (rsp_seen != saved) begin
         bad++;
         $display("FAIL rst_no_rsp responses=%0d expected %0d", rsp_seen, saved);
      end
      stub_on = 1'b1;
      push_exp(32'h00000579, 3'd4, 2);
      @(posedge CLK); #1;
      Req_valid = '0;
      run_ops(1, 1'b0, 20, "rst_next");
   endtask

   task automatic test_drain_hold();
      int n;
      bit found;
      n     = 0;
      found = 1'b0;
      stub_on   = 1'b1;
      stub_hold = 5;
      @(posedge CLK); #1;
      set_slot(3, 32'h00ABC000, 32'h00000DEF, 3'd6);
      set_slot(0, 32'h00000010, 32'h00000020, 3'd1);
      push_exp(32'h00ABCDEF, 3'd6, 3);
      Req_valid = 4'b1000;
      @(posedge CLK); #1;
      Req_valid = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (Rsp_valid !== '0) begin
            found = 1'b1;
            break;
         end
      end
      for (int c = 0; c < 20 && found && Busy === 1'b1 && Dataout_valid === 1'b1; c++) begin
         if (Req_ready !== '0) begin
            total++;
            bad++;
            $display("FAIL drain_ready_hold Req_ready=%b expected 0000", Req_ready);
         end
         n++;
         @(negedge CLK);
      end
      total++;
      if (!found || n != 5) begin
         bad++;
         $display("FAIL drain_cycles held_cycles=%0d response_seen=%0d expected 5 and 1", n, found);
      end
      for (int c = 0; c < 10 && Busy === 1'b1; c++) begin
         total++;
         if (Req_ready !== '0) begin
            bad++;
            $display("FAIL drain_exit_ready Req_ready=%b expected 0000", Req_ready);
         end
         @(negedge CLK);
      end
      total++;
      if (Busy !== 1'b0 || Dataout_valid !== 1'b0 || Req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL drain_first_idle busy=%b dout_valid=%b ready=%b expected 0 0 0001",
                  Busy, Dataout_valid, Req_ready);
      end
      stub_hold = 0;
      push_exp(32'h00000030, 3'd1, 0);
      @(posedge CLK); #1;
      Req_valid = '0;
      run_ops(1, 1'b0, 20, "drain_next");
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rsp_seen   = 0;
      stub_on    = 1'b0;
      stub_hold  = 0;
      stub_force = 0;
      Req_valid  = '0;
      Req_data1  = '0;
      Req_data2  = '0;
      Req_mode   = '0;
      RST        = 1'b1;

      test_reset();
      test_single();
      test_simultaneous();
      test_round_robin();
      test_timeout();
      test_reset_in_issue();
      test_drain_hold();

      repeat (3) @(negedge CLK);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover pending=%0d expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
